// File: rtl/riscv_intc_pkg.sv
// rtl/riscv_intc_pkg.sv - shared interrupt controller types, widths and encoder
// The gateway and the controller both use prio_enc so cause codes always agree.
package riscv_intc_pkg;

  localparam int NUMINT   = 16;
  localparam int INT_ID_W = $clog2(NUMINT);

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_mode_e;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [INT_ID_W-1:0] prio_enc(input logic [NUMINT-1:0] v);
    prio_enc = '0;
    for (int i = NUMINT - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = INT_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/riscv_irq_gateway_if.sv
// rtl/riscv_irq_gateway_if.sv - interrupt lines and claim/complete handshake bundle
// master drives raw lines and software pulses; slave is the gateway.
interface riscv_irq_gateway_if #(
  parameter int NUMINT   = riscv_intc_pkg::NUMINT,
  parameter int INT_ID_W = riscv_intc_pkg::INT_ID_W
);

  logic [NUMINT-1:0]   irq_raw_i;
  logic [NUMINT-1:0]   trig_edge_i;
  logic [NUMINT-1:0]   en_mask_i;
  logic [NUMINT-1:0]   ext_int_o;
  logic                claim_valid_o;
  logic [INT_ID_W-1:0] claim_id_o;
  logic                claim_i;
  logic                complete_i;
  logic [INT_ID_W-1:0] complete_id_i;
  logic [NUMINT-1:0]   in_service_o;

  modport master (
    output irq_raw_i, trig_edge_i, en_mask_i, claim_i, complete_i, complete_id_i,
    input  ext_int_o, claim_valid_o, claim_id_o, in_service_o
  );

  modport slave (
    input  irq_raw_i, trig_edge_i, en_mask_i, claim_i, complete_i, complete_id_i,
    output ext_int_o, claim_valid_o, claim_id_o, in_service_o
  );

endinterface

// File: rtl/riscv_sync_ff.sv
// rtl/riscv_sync_ff.sv - multi-stage flip-flop synchroniser for asynchronous inputs
module riscv_sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_i
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_i = stage_q[STAGES-1];

endmodule

// File: rtl/riscv_irq_gateway.sv
// rtl/riscv_irq_gateway.sv - external interrupt gateway: sync, trigger, mask, claim/complete
// Outputs depend only on registers and en_mask_i; claim/complete act at the clock edge.
module riscv_irq_gateway #(
  parameter int NUMINT      = riscv_intc_pkg::NUMINT,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  riscv_irq_gateway_if.slave  bus
);

  import riscv_intc_pkg::*;

  logic [NUMINT-1:0] sync_q;
  logic [NUMINT-1:0] prev_sync_q;
  logic [NUMINT-1:0] rise;
  logic [NUMINT-1:0] pending_q;
  logic [NUMINT-1:0] pending_d;
  logic [NUMINT-1:0] in_service_q;
  logic [NUMINT-1:0] in_service_d;
  logic [NUMINT-1:0] ext_int;
  logic [NUMINT-1:0] claim_oh;
  logic [NUMINT-1:0] complete_oh;
  logic              claim_fire;

  riscv_sync_ff #(
    .WIDTH  (NUMINT),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.irq_raw_i),
    .q_i   (sync_q)
  );

  assign rise       = sync_q & ~prev_sync_q;
  assign ext_int    = pending_q & bus.en_mask_i & ~in_service_q;
  assign claim_fire = bus.claim_i & (|ext_int);

  always_comb begin
    claim_oh    = '0;
    complete_oh = '0;
    if (claim_fire) begin
      claim_oh[bus.claim_id_o] = 1'b1;
    end
    if (bus.complete_i && (32'(bus.complete_id_i) < NUMINT)) begin
      complete_oh[bus.complete_id_i] = 1'b1;
    end
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUMINT; i++) begin
      if (trig_mode_e'(bus.trig_edge_i[i]) == TRIG_EDGE) begin
        // A fresh edge beats a coincident claim so it is not lost.
        pending_d[i] = rise[i] | (pending_q[i] & ~claim_oh[i]);
      end else if (in_service_q[i] || claim_oh[i]) begin
        pending_d[i] = pending_q[i] & ~claim_oh[i];
      end else begin
        pending_d[i] = sync_q[i];
      end
    end
    // Complete wins over a same-id claim.
    in_service_d = (in_service_q | claim_oh) & ~complete_oh;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_sync_q  <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      prev_sync_q  <= sync_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.ext_int_o     = ext_int;
  assign bus.claim_valid_o = |ext_int;
  assign bus.claim_id_o    = prio_enc(ext_int);
  assign bus.in_service_o  = in_service_q;

endmodule
